alu_issue_stage: RTL and testbench

- Operand-issue stage directly upstream of the 8-bit ALU.
- Accepts decoded ALU ops from decode through a valid/ready handshake. Reads the two source registers from the register file, applies writeback forwarding and immediate select, then buffers resolved ops in a 2-entry FIFO.
- Presents ctrl/a/b/rd to the ALU and writeback path. Interlocks read-after-write hazards against ops it still holds.

---
 rtl/alu_issue_stage.sv | 98 +++++++++
 tb/tb_alu_issue_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue into a 2-entry FIFO ahead of the ALU; define ALU_ISSUE_FWD_EN for writeback forwarding
module alu_issue_stage #(
  parameter int CTRL_W  = 4,
  parameter int RADDR_W = 3,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [RADDR_W-1:0] in_rs,
  input  logic [RADDR_W-1:0] in_rt,
  input  logic [7:0]         in_imm,
  input  logic               in_use_imm,
  output logic [RADDR_W-1:0] rf_rs_addr,
  output logic [RADDR_W-1:0] rf_rt_addr,
  input  logic [7:0]         rf_rs_data,
  input  logic [7:0]         rf_rt_data,
  input  logic               fwd_valid,
  input  logic [RADDR_W-1:0] fwd_rd,
  input  logic [7:0]         fwd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [7:0]         out_a,
  output logic [7:0]         out_b,
  output logic [RADDR_W-1:0] out_rd
);
  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [7:0]         a;
    logic [7:0]         b;
    logic [RADDR_W-1:0] rd;
  } ent_t;
  ent_t e0, e1, nw;
  logic v0, v1, fa, fb, lh, hz, push, pop;
  logic [1:0] cnt;
  function automatic logic hit(input logic [RADDR_W-1:0] rd);
    return rd == in_rs || (!in_use_imm && rd == in_rt);
  endfunction
  assign rf_rs_addr = in_rs;
  assign rf_rt_addr = in_rt;
`ifdef ALU_ISSUE_FWD_EN
  assign fa = fwd_valid && fwd_rd == in_rs;
  assign fb = fwd_valid && fwd_rd == in_rt;
  assign lh = 1'b0;
`else
  // without forwarding, the op issued last cycle is still being written back
  logic lv;
  logic [RADDR_W-1:0] lrd;
  logic unused_fwd;
  assign unused_fwd = &{1'b0, fwd_valid, fwd_rd};
  assign fa = 1'b0;
  assign fb = 1'b0;
  assign lh = lv && hit(lrd);
  always_ff @(posedge clk) begin
    lv <= reset ? 1'b0 : pop;
    lrd <= e0.rd;
  end
`endif
  always_comb begin
    nw.ctrl = in_ctrl;
    nw.a = fa ? fwd_data : rf_rs_data;
    nw.b = in_use_imm ? in_imm : fb ? fwd_data : rf_rt_data;
    nw.rd = in_rd;
  end
  assign cnt = {1'b0, v0} + {1'b0, v1};
  assign hz = (v0 && hit(e0.rd)) || (v1 && hit(e1.rd)) || lh;
  assign in_ready = !reset && cnt < 2'(DEPTH) && !hz;
  assign push = in_valid && in_ready;
  assign pop = v0 && out_ready;
  // entries shift toward e0; a full buffer never pushes, so pop+push only occurs with e1 empty
  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (pop) begin
      e0 <= v1 ? e1 : nw;
      v0 <= v1 || push;
      v1 <= 1'b0;
    end else if (push) begin
      if (v0) begin
        e1 <= nw;
        v1 <= 1'b1;
      end else begin
        e0 <= nw;
        v0 <= 1'b1;
      end
    end
  end
  assign out_valid = v0;
  assign out_ctrl = e0.ctrl;
  assign out_a = e0.a;
  assign out_b = e0.b;
  assign out_rd = e0.rd;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of alu_issue_stage in either ALU_ISSUE_FWD_EN build
module tb_alu_issue_stage;
  logic clk = 1'b0, reset, in_valid, in_ready, in_use_imm, fwd_valid, out_valid, out_ready;
  logic [3:0] in_ctrl, out_ctrl;
  logic [2:0] in_rd, in_rs, in_rt, rf_rs_addr, rf_rt_addr, fwd_rd, out_rd;
  logic [7:0] in_imm, rf_rs_data, rf_rt_data, fwd_data, out_a, out_b;
  int checks = 0, errors = 0;
`ifdef ALU_ISSUE_FWD_EN
  localparam logic [7:0] T3_A = 8'hA5, T4_A = 8'h77;
`else
  localparam logic [7:0] T3_A = 8'h5A, T4_A = 8'h11;
`endif
  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_a(out_a), .out_b(out_b), .out_rd(out_rd)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [3:0] c, input logic [2:0] d, s, t, input logic [7:0] im,
                    input logic ui, input logic [7:0] rsd, rtd);
    in_valid = 1'b1; in_ctrl = c; in_rd = d; in_rs = s; in_rt = t;
    in_imm = im; in_use_imm = ui; rf_rs_data = rsd; rf_rt_data = rtd;
  endtask
  initial begin
    reset = 1'b1; out_ready = 1'b0; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    op(4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00);
    in_valid = 1'b0;
    step(); step();
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    reset = 1'b0; #1;
    check("idle_ready", in_ready, 1);
    // basic issue with t+1 latency
    out_ready = 1'b1;
    op(4'h2, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'h12, 8'h34); #1;
    check("t1_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_a", out_a, 8'h12);
    check("t1_b", out_b, 8'h34);
    check("t1_rd", out_rd, 3);
    check("t1_ctrl", out_ctrl, 4'h2);
    step(); check("t1_empty", out_valid, 0);
    step();
    // fill, stall on full, drain in order
    out_ready = 1'b0;
    op(4'h1, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0, 8'h01, 8'h02); #1;
    check("t2_acc_a", in_ready, 1);
    step();
    op(4'h1, 3'd6, 3'd1, 3'd2, 8'h00, 1'b0, 8'h03, 8'h04); #1;
    check("t2_acc_b", in_ready, 1);
    step();
    op(4'h1, 3'd7, 3'd2, 3'd1, 8'h00, 1'b0, 8'h05, 8'h06); #1;
    check("t2_full", in_ready, 0);
    check("t2_head_a", out_a, 8'h01);
    step(); check("t2_full2", in_ready, 0);
    out_ready = 1'b1; #1;
    check("t2_full_rdy", in_ready, 0);
    step();
    check("t2_head_b_rd", out_rd, 6);
    check("t2_head_b_a", out_a, 8'h03);
    check("t2_c_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    check("t2_head_c_rd", out_rd, 7);
    check("t2_head_c_a", out_a, 8'h05);
    check("t2_head_c_b", out_b, 8'h06);
    step(); check("t2_drain", out_valid, 0);
    step();
    // RAW hazard against a buffered rd=4
    out_ready = 1'b0;
    op(4'h1, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0, 8'h10, 8'h20); #1;
    check("t3_acc_d", in_ready, 1);
    step();
    op(4'h3, 3'd5, 3'd4, 3'd1, 8'h00, 1'b0, 8'h99, 8'h21); #1;
    check("t3_haz", in_ready, 0);
    step(); check("t3_haz2", in_ready, 0);
    out_ready = 1'b1; #1;
    check("t3_haz3", in_ready, 0);
    step();
    fwd_valid = 1'b1; fwd_rd = 3'd4; fwd_data = 8'hA5; #1;
`ifndef ALU_ISSUE_FWD_EN
    check("t3_last_issued", in_ready, 0);
    step();
    fwd_valid = 1'b0; rf_rs_data = 8'h5A; #1;
`endif
    check("t3_go", in_ready, 1);
    step(); in_valid = 1'b0; fwd_valid = 1'b0;
    check("t3_a", out_a, T3_A);
    check("t3_b", out_b, 8'h21);
    check("t3_rd", out_rd, 5);
    step(); check("t3_drain", out_valid, 0);
    step();
    // forwarding select, then immediate bypasses the rt hazard
    out_ready = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 3'd0; fwd_data = 8'h77;
    op(4'h4, 3'd2, 3'd0, 3'd1, 8'h00, 1'b0, 8'h11, 8'h31); #1;
    check("t4_acc_f", in_ready, 1);
    step(); fwd_valid = 1'b0;
    check("t4_fwd_a", out_a, T4_A);
    check("t4_fwd_b", out_b, 8'h31);
    op(4'h5, 3'd3, 3'd1, 3'd2, 8'hFF, 1'b0, 8'h40, 8'h44); #1;
    check("t4_rt_haz", in_ready, 0);
    in_use_imm = 1'b1; #1;
    check("t4_imm_ok", in_ready, 1);
    step(); in_valid = 1'b0;
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    check("t4_imm_b", out_b, 8'hFF);
    check("t4_imm_a", out_a, 8'h40);
    check("t4_imm_rd", out_rd, 3);
    // reset with two entries buffered
    op(4'h6, 3'd0, 3'd5, 3'd6, 8'h00, 1'b0, 8'h01, 8'h02); #1;
    check("t5_acc_j", in_ready, 1);
    step();
    op(4'h6, 3'd1, 3'd6, 3'd5, 8'h00, 1'b0, 8'h01, 8'h02);
    check("t5_two", out_valid, 1);
    check("t5_full", in_ready, 0);
    reset = 1'b1; out_ready = 1'b1; #1;
    check("t5_rst_ready", in_ready, 0);
    step();
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready2", in_ready, 0);
    reset = 1'b0; in_valid = 1'b0; #1;
    check("t5_post_ready", in_ready, 1);
    step(); check("t5_no_issue", out_valid, 0);
    op(4'h7, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 8'h55, 8'h66); #1;
    check("t5_acc_i", in_ready, 1);
    step(); in_valid = 1'b0;
    check("t5_valid", out_valid, 1);
    check("t5_a", out_a, 8'h55);
    check("t5_b", out_b, 8'h66);
    check("t5_rd", out_rd, 1);
    check("t5_ctrl", out_ctrl, 4'h7);
    step(); check("t5_drain", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
